// File: rtl/gate_sequencer.sv
// Steps a 2-bit stimulus through a switch/LED gate datapath and checks the returned outputs.
// Each pattern takes APPLY, SETTLE cycles, CHECK and TICK_DIV HOLD cycles; all outputs are registered.
module gate_sequencer #(
  parameter int TICK_DIV = 100000000,
  parameter int SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic [1:0] dut_sw,
  input  logic [1:0] dut_led,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [3:0] err_cnt,
  output logic [1:0] pat_idx
);

  localparam int HW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HW-1:0] HOLD_LOAD   = HW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_HOLD, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          prev_q, prev_d;
  logic [1:0]    fill_q, fill_d;
  logic          start_edge;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]    dut_sw_q, dut_sw_d;
  logic          busy_q, busy_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic [3:0]    err_cnt_q, err_cnt_d;
  logic [1:0]    pat_idx_q, pat_idx_d;
  logic [1:0]    expected;

  // prev starts high and only tracks the synchronizer once it holds real samples,
  // so a start level already high at reset release cannot look like an edge.
  always_comb begin
    fill_d     = fill_q[1] ? fill_q : fill_q + 2'd1;
    prev_d     = fill_q[1] ? sync2_q : 1'b1;
    start_edge = fill_q[1] & sync2_q & ~prev_q;
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    fail_d       = fail_q;
    err_cnt_d    = err_cnt_q;
    pat_idx_d    = pat_idx_q;
    expected     = {~pat_idx_q[1], pat_idx_q[0] ^ pat_idx_q[1]};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          pat_idx_d = 2'b00;
          err_cnt_d = 4'd0;
          fail_d    = 1'b0;
          state_d   = S_APPLY;
        end
      end
      S_APPLY: begin
        settle_cnt_d = SETTLE_LOAD;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) state_d = S_CHECK;
        else                    settle_cnt_d = settle_cnt_q - 1'b1;
      end
      S_CHECK: begin
        if (dut_led != expected) begin
          fail_d = 1'b1;
          if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
        end
        hold_cnt_d = HOLD_LOAD;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          if (pat_idx_q != 2'b11) begin
            pat_idx_d = pat_idx_q + 2'd1;
            state_d   = S_APPLY;
          end else if (mode) begin
            pat_idx_d = 2'b00;
            state_d   = S_APPLY;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they line up with the state register.
    busy_d   = (state_d == S_APPLY) || (state_d == S_SETTLE) ||
               (state_d == S_CHECK) || (state_d == S_HOLD);
    pass_d   = (state_d == S_DONE) && !fail_d;
    dut_sw_d = (state_d == S_APPLY) ? pat_idx_d : dut_sw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b1;
      fill_q       <= 2'd0;
      settle_cnt_q <= '0;
      hold_cnt_q   <= '0;
      dut_sw_q     <= 2'b00;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      err_cnt_q    <= 4'd0;
      pat_idx_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      sync1_q      <= start;
      sync2_q      <= sync1_q;
      prev_q       <= prev_d;
      fill_q       <= fill_d;
      settle_cnt_q <= settle_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      dut_sw_q     <= dut_sw_d;
      busy_q       <= busy_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      err_cnt_q    <= err_cnt_d;
      pat_idx_q    <= pat_idx_d;
    end
  end

  assign dut_sw  = dut_sw_q;
  assign busy    = busy_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign err_cnt = err_cnt_q;
  assign pat_idx = pat_idx_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer with TICK_DIV=4, SETTLE=2 (8 cycles per pattern).
module tb_gate_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [1:0] dut_sw;
  logic [1:0] dut_led;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [3:0] err_cnt;
  logic [1:0] pat_idx;

  logic stuck0;
  logic stuck1;
  int   n_chk;
  int   n_pass;
  int   cyc;
  int   e;

  gate_sequencer #(.TICK_DIV(4), .SETTLE(2)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .dut_sw  (dut_sw),
    .dut_led (dut_led),
    .busy    (busy),
    .pass    (pass),
    .fail    (fail),
    .err_cnt (err_cnt),
    .pat_idx (pat_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External gate model with optional stuck-at faults.
  always_comb begin
    dut_led = {~dut_sw[1], dut_sw[0] ^ dut_sw[1]};
    if (stuck0) dut_led[0] = 1'b0;
    if (stuck1) dut_led[1] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse_start(input string tag, output int entry);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy) break;
      tick();
    end
    entry = cyc;
    check(tag, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = 1'b0;
    stuck0 = 1'b0;
    stuck1 = 1'b0;
    #2;
    check("rst_outputs", {24'd0, dut_sw, busy, pass, fail, err_cnt, pat_idx}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick_to(6);

    // Clean single pass
    pulse_start("p1_busy", e);
    check("p1_sw0", {30'd0, dut_sw}, 32'd0);
    tick_to(e + 8);
    check("p1_sw1", {30'd0, dut_sw}, 32'd1);
    tick_to(e + 16);
    check("p1_sw2", {30'd0, dut_sw}, 32'd2);
    tick_to(e + 24);
    check("p1_sw3", {30'd0, dut_sw}, 32'd3);
    tick_to(e + 31);
    check("p1_busy_last", {31'd0, busy}, 32'd1);
    tick_to(e + 32);
    check("p1_done", {27'd0, busy, pass, fail, err_cnt == 4'd0, 1'b0}, 32'b01010);
    check("p1_sw_held", {30'd0, dut_sw}, 32'd3);

    // dut_led[0] stuck low: mismatches on 01 and 10
    stuck0 = 1'b1;
    pulse_start("p2_busy", e);
    check("p2_err_clr", {28'd0, err_cnt}, 32'd0);
    tick_to(e + 12);
    check("p2_err_first", {27'd0, fail, err_cnt}, {27'd0, 1'b1, 4'd1});
    tick_to(e + 32);
    check("p2_done", {29'd0, busy, pass, fail}, 32'b001);
    check("p2_err", {28'd0, err_cnt}, 32'd2);
    stuck0 = 1'b0;

    // dut_led[1] stuck high, looping: err_cnt saturates
    stuck1 = 1'b1;
    mode   = 1'b1;
    pulse_start("p3_busy", e);
    tick_to(e + 32);
    check("p3_wrap", {26'd0, busy, pat_idx, 1'b0, err_cnt == 4'd2}, {26'd0, 1'b1, 2'b00, 1'b0, 1'b1});
    tick_to(e + 320);
    check("p3_sat", {28'd0, err_cnt}, 32'd15);
    check("p3_flags", {29'd0, busy, pass, fail}, 32'b101);
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    stuck1 = 1'b0;
    mode   = 1'b0;
    tick();

    // Reset during HOLD of pattern 10
    pulse_start("p4_busy", e);
    tick_to(e + 21);
    check("p4_pre_rst", {28'd0, busy, 1'b0, pat_idx}, 32'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    check("p4_async_rst", {24'd0, dut_sw, busy, pass, fail, err_cnt, pat_idx}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("p4_idle", {29'd0, busy, dut_sw}, 32'd0);

    // Second start edge during pattern 01 is ignored
    pulse_start("p5_busy", e);
    tick_to(e + 9);
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    tick_to(e + 16);
    check("p5_sw2", {30'd0, dut_sw}, 32'd2);
    tick_to(e + 31);
    check("p5_busy_last", {31'd0, busy}, 32'd1);
    tick_to(e + 32);
    check("p5_done", {30'd0, busy, pass}, 32'b01);

    // Start held high across reset release
    start = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("p6_no_run", {29'd0, busy, dut_sw}, 32'd0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    pulse_start("p6_busy", e);
    tick_to(e + 8);
    check("p6_sw1", {30'd0, dut_sw}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
